// File: rtl/dpram_pkg.sv
// ============================================================================
// Module   : dpram_pkg
// Purpose  : Shared types and defaults for the dpram block and the port-A
//            arbiter in front of it.
// Contents : st_t      - arbiter state (IDLE, BUSY)
//            DEF_AW/DW - default RAM address/data widths
//            iw_of()   - index width for a requester count
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dpram_pkg;

  localparam int DEF_AW = 5;
  localparam int DEF_DW = 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } st_t;

  // Width of an index into NR items; never below 1 so single-bit
  // vectors stay legal for degenerate counts.
  function automatic int iw_of(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dpram.sv
// ============================================================================
// Module   : dpram
// Purpose  : Dual-port RAM. Port A reads and writes, port X reads only.
//            Both ports register their address, so the read data follows
//            the address of the previous enabled edge, and a write on port A
//            is visible on dat_o in the following cycle.
// Ports    : clk_i  - clock
//            ena_i  - clock enable for both ports (low holds everything)
//            adr_i  - port A address     dat_i  - port A write data
//            wre_i  - port A write enable dat_o - port A read data
//            adrx_i - port X address     datx_o - port X read data
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dpram
  import dpram_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic          clk_i,
  input  logic          ena_i,
  input  logic [AW-1:0] adr_i,
  input  logic [DW-1:0] dat_i,
  input  logic          wre_i,
  output logic [DW-1:0] dat_o,
  input  logic [AW-1:0] adrx_i,
  output logic [DW-1:0] datx_o
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [0:DEPTH-1];
  logic [AW-1:0] adr_q;
  logic [AW-1:0] adrx_q;

  always_ff @(posedge clk_i) begin
    if (ena_i) begin
      if (wre_i) begin
        mem_q[adr_i] <= dat_i;
      end
      adr_q  <= adr_i;
      adrx_q <= adrx_i;
    end
  end

  assign dat_o  = mem_q[adr_q];
  assign datx_o = mem_q[adrx_q];

endmodule

`default_nettype wire

// File: rtl/dpram_arb_rr_pick.sv
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational rotating priority encoder. Scans req_i starting at
//            index ptr_i and wrapping modulo NR; the first set bit wins.
//            With ptr_i tied to zero it is a plain lowest-index-first encoder.
// Ports    : req_i - eligible request mask
//            ptr_i - scan start index
//            win_o - winning index (0 when nothing is requested)
//            vld_o - at least one request present
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
  import dpram_pkg::*;
#(
  parameter int NR = 2,
  parameter int IW = iw_of(NR)
) (
  input  logic [NR-1:0] req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] win_o,
  output logic          vld_o
);

  int idx;

  // Walk the offsets from the far end back to zero so that the candidate
  // closest to ptr_i is the last one written and therefore wins.
  always_comb begin
    win_o = '0;
    vld_o = 1'b0;
    idx   = 0;
    for (int j = NR - 1; j >= 0; j--) begin
      idx = int'(ptr_i) + j;
      if (idx >= NR) begin
        idx = idx - NR;
      end
      if (req_i[IW'(idx)]) begin
        vld_o = 1'b1;
        win_o = IW'(idx);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/dpram_arb.sv
// ============================================================================
// Module   : dpram_arb
// Purpose  : Shares dpram port A between NR strobe/acknowledge requesters.
//            A request issued in cycle t drives the RAM address/data/write
//            enable combinationally and is acknowledged in t+1, together
//            with the RAM read data from the registered address.
//            Build option DPRAM_ARB_PRIO_EN selects fixed lowest-index
//            priority instead of round-robin.
// Ports    : clk_i, rst_i (async, active-high), ena_i (global enable)
//            stb_i/we_i [NR]        - requests and write qualifiers
//            adr_i [NR*AW], dat_i [NR*DW] - packed per requester
//            ack_o [NR]  - one-hot completion, dat_o - broadcast read data
//            ram_adr_o, ram_dat_o, ram_wre_o, ram_ena_o -> dpram port A
//            ram_dat_i  <- dpram port A read data
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dpram_arb
  import dpram_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW,
  parameter int NR = 2
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           ena_i,
  input  logic [NR-1:0]    stb_i,
  input  logic [NR-1:0]    we_i,
  input  logic [NR*AW-1:0] adr_i,
  input  logic [NR*DW-1:0] dat_i,
  output logic [NR-1:0]    ack_o,
  output logic [DW-1:0]    dat_o,
  output logic [AW-1:0]    ram_adr_o,
  output logic [DW-1:0]    ram_dat_o,
  output logic             ram_wre_o,
  output logic             ram_ena_o,
  input  logic [DW-1:0]    ram_dat_i
);

  localparam int IW = iw_of(NR);

  st_t           st_q, st_d;
  logic [IW-1:0] cur_q, cur_d;
  logic [IW-1:0] ptr_w;
  logic [NR-1:0] cur_oh_w;
  logic [NR-1:0] elig_w;
  logic [IW-1:0] win_w;
  logic          vld_w;
  logic          issue_w;

  assign cur_oh_w = NR'(1) << cur_q;

  // The requester being acknowledged still holds its strobe this cycle;
  // masking it keeps it from being issued twice for one transfer.
  assign elig_w = stb_i & ~((st_q == BUSY) ? cur_oh_w : '0);

  // Scan-start pointer
`ifdef DPRAM_ARB_PRIO_EN
  assign ptr_w = '0;
`else
  localparam logic [IW-1:0] LAST = IW'(NR - 1);

  logic [IW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (ena_i && issue_w) begin
      ptr_d = (win_w == LAST) ? '0 : win_w + IW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_w = ptr_q;
`endif

  rr_pick #(
    .NR (NR),
    .IW (IW)
  ) u_pick (
    .req_i (elig_w),
    .ptr_i (ptr_w),
    .win_o (win_w),
    .vld_o (vld_w)
  );

  // Reset is folded in so the RAM sees no address or write while it is held.
  assign issue_w = vld_w & ena_i & ~rst_i;

  // RAM port A drive
  always_comb begin
    ram_adr_o = '0;
    ram_dat_o = '0;
    ram_wre_o = 1'b0;
    if (issue_w) begin
      ram_adr_o = adr_i[int'(win_w)*AW +: AW];
      ram_dat_o = dat_i[int'(win_w)*DW +: DW];
      ram_wre_o = we_i[win_w];
    end
  end

  assign ram_ena_o = ena_i;

  // Next-state: everything is held while ena_i is low.
  always_comb begin
    st_d  = st_q;
    cur_d = cur_q;
    if (ena_i) begin
      if (issue_w) begin
        st_d  = BUSY;
        cur_d = win_w;
      end else begin
        st_d  = IDLE;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      st_q  <= IDLE;
      cur_q <= '0;
    end else begin
      st_q  <= st_d;
      cur_q <= cur_d;
    end
  end

  // Completion and read data. The RAM freezes its registered address while
  // ena_i is low, so ram_dat_i is still correct when the ack finally fires.
  always_comb begin
    ack_o = '0;
    if ((st_q == BUSY) && ena_i) begin
      ack_o = cur_oh_w;
    end
  end

  assign dat_o = ram_dat_i;

endmodule

`default_nettype wire

// File: tb/tb_dpram_arb.sv
// ============================================================================
// Module   : tb_dpram_arb
// Purpose  : Self-checking bench for dpram_arb driving a dpram (AW=5, DW=2).
//            Directed sequences with literal expectations, then randomized
//            requesters obeying the hold-until-ack handshake, all compared
//            every cycle against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dpram_arb;

  localparam int AW = 5;
  localparam int DW = 2;
  localparam int NR = 2;

  logic             clk;
  logic             rst;
  logic             ena;
  logic [NR-1:0]    stb;
  logic [NR-1:0]    we;
  logic [NR*AW-1:0] adr;
  logic [NR*DW-1:0] dat;
  logic [AW-1:0]    adrx;

  wire  [NR-1:0]    ack_o;
  wire  [DW-1:0]    dat_o;
  wire  [AW-1:0]    ram_adr_o;
  wire  [DW-1:0]    ram_dat_o;
  wire              ram_wre_o;
  wire              ram_ena_o;
  wire  [DW-1:0]    ram_dat_i;
  wire  [DW-1:0]    datx_o;

  dpram_arb #(.AW(AW), .DW(DW), .NR(NR)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .ena_i     (ena),
    .stb_i     (stb),
    .we_i      (we),
    .adr_i     (adr),
    .dat_i     (dat),
    .ack_o     (ack_o),
    .dat_o     (dat_o),
    .ram_adr_o (ram_adr_o),
    .ram_dat_o (ram_dat_o),
    .ram_wre_o (ram_wre_o),
    .ram_ena_o (ram_ena_o),
    .ram_dat_i (ram_dat_i)
  );

  dpram #(.AW(AW), .DW(DW)) u_ram (
    .clk_i  (clk),
    .ena_i  (ram_ena_o),
    .adr_i  (ram_adr_o),
    .dat_i  (ram_dat_o),
    .wre_i  (ram_wre_o),
    .dat_o  (ram_dat_i),
    .adrx_i (adrx),
    .datx_o (datx_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;
  bit started = 1'b0;

  task automatic chk(input string nm, input int act, input int want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, want, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model: who is owed an ack, where the scan starts, and the
  // RAM contents; the expected read data is fixed at issue time.
  // ---------------------------------------------------------------------
  bit          m_busy;
  int          m_cur;
  int          m_ptr;
  int          m_mem   [0:(1<<AW)-1];
  bit          m_known [0:(1<<AW)-1];
  bit          pend_known;
  int          pend_dat;

  logic [NR-1:0] e_elig;
  bit            e_iss;
  int            e_win, e_adr, e_dat, e_wre, e_ack;

  always @(negedge clk) begin
    if (started) begin
      if (rst) begin
        chk("rst_ack", int'(ack_o), 0);
        chk("rst_wre", int'(ram_wre_o), 0);
        chk("rst_adr", int'(ram_adr_o), 0);
        m_busy     = 1'b0;
        m_cur      = 0;
        m_ptr      = 0;
        pend_known = 1'b0;
      end else begin
        e_elig = stb;
        if (m_busy) e_elig[m_cur] = 1'b0;
        e_iss = 1'b0;
        e_win = 0;
        if (ena) begin
          for (int k = 0; k < NR; k++) begin
            if (!e_iss && e_elig[(m_ptr + k) % NR]) begin
              e_iss = 1'b1;
              e_win = (m_ptr + k) % NR;
            end
          end
        end
        e_adr = e_iss ? int'(adr[e_win*AW +: AW]) : 0;
        e_dat = e_iss ? int'(dat[e_win*DW +: DW]) : 0;
        e_wre = e_iss ? int'(we[e_win]) : 0;
        e_ack = (m_busy && ena) ? (1 << m_cur) : 0;

        chk("ram_adr", int'(ram_adr_o), e_adr);
        chk("ram_dat", int'(ram_dat_o), e_dat);
        chk("ram_wre", int'(ram_wre_o), e_wre);
        chk("ram_ena", int'(ram_ena_o), int'(ena));
        chk("ack",     int'(ack_o),     e_ack);
        if (e_ack != 0 && pend_known) chk("dat_o", int'(dat_o), pend_dat);

        if (ena) begin
          if (e_iss) begin
            if (e_wre != 0) begin
              pend_known = 1'b1;
              pend_dat   = e_dat;
              m_mem[e_adr]   = e_dat;
              m_known[e_adr] = 1'b1;
            end else begin
              pend_known = m_known[e_adr];
              pend_dat   = m_mem[e_adr];
            end
            m_busy = 1'b1;
            m_cur  = e_win;
`ifdef DPRAM_ARB_PRIO_EN
            m_ptr  = 0;
`else
            m_ptr  = (e_win + 1) % NR;
`endif
          end else begin
            m_busy = 1'b0;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk); #1;
  endtask

  logic [NR-1:0] a_smp;

  initial begin
    for (int i = 0; i < (1<<AW); i++) begin
      m_mem[i]   = 0;
      m_known[i] = 1'b0;
    end
    rst = 1'b1; ena = 1'b1; stb = '0; we = '0; adr = '0; dat = '0;
    adrx = 5'd3;
    repeat (3) @(posedge clk);
    started = 1'b1;
    mid();
    chk("reset_ack", int'(ack_o), 0);
    chk("reset_wre", int'(ram_wre_o), 0);
    chk("reset_adr", int'(ram_adr_o), 0);
    chk("reset_wdat", int'(ram_dat_o), 0);
    nxt(); rst = 1'b0;

    // requester 0 writes 2'b10 to address 3
    nxt(); stb = 2'b01; we = 2'b01; adr = {5'd0, 5'd3}; dat = {2'd0, 2'b10};
    mid();
    chk("wr_wre", int'(ram_wre_o), 1);
    chk("wr_adr", int'(ram_adr_o), 3);
    chk("wr_dat", int'(ram_dat_o), 2);
    chk("wr_noack", int'(ack_o), 0);
    nxt(); mid();
    chk("wr_ack", int'(ack_o), 1);
    chk("wr_dato", int'(dat_o), 2);
    chk("wr_ackcyc_wre", int'(ram_wre_o), 0);
    nxt(); stb = '0; we = '0;

    // requester 1 reads it back
    nxt(); stb = 2'b10; adr = {5'd3, 5'd0};
    mid();
    chk("rd_adr", int'(ram_adr_o), 3);
    chk("rd_wre", int'(ram_wre_o), 0);
    nxt(); mid();
    chk("rd_ack", int'(ack_o), 2);
    chk("rd_dato", int'(dat_o), 2);
    nxt(); stb = '0;

    // both requesters streaming: grants alternate, ack every cycle
    nxt(); stb = 2'b11; adr = {5'd2, 5'd1};
    mid();
    chk("alt_first_adr", int'(ram_adr_o), 1);
    chk("alt_first_ack", int'(ack_o), 0);
    for (int i = 0; i < 4; i++) begin
      nxt(); mid();
      chk("alt_ack", int'(ack_o), (i % 2 == 0) ? 1 : 2);
      chk("alt_adr", int'(ram_adr_o), (i % 2 == 0) ? 2 : 1);
    end
    nxt(); stb = '0;
    nxt();

    // lone requester: one access every two cycles
    nxt(); stb = 2'b01; adr = {5'd0, 5'd3};
    mid();
    chk("lone_first_ack", int'(ack_o), 0);
    for (int i = 0; i < 5; i++) begin
      nxt(); mid();
      chk("lone_ack", int'(ack_o), (i % 2 == 0) ? 1 : 0);
      if (i % 2 == 0) chk("lone_dato", int'(dat_o), 2);
    end
    nxt(); stb = '0;

    // enable dropped for three cycles while an ack is pending
    nxt(); stb = 2'b01; adr = {5'd0, 5'd3};
    mid();
    chk("ena_issue_adr", int'(ram_adr_o), 3);
    nxt(); ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("ena_off_ack", int'(ack_o), 0);
      chk("ena_off_adr", int'(ram_adr_o), 0);
      if (i < 2) nxt();
    end
    nxt(); ena = 1'b1;
    mid();
    chk("ena_back_ack", int'(ack_o), 1);
    chk("ena_back_dato", int'(dat_o), 2);
    nxt(); stb = '0;

    // reset during the ack cycle of a write to address 5
    nxt(); stb = 2'b01; we = 2'b01; adr = {5'd0, 5'd5}; dat = {2'd0, 2'b01};
    mid();
    chk("rstw_wre", int'(ram_wre_o), 1);
    chk("rstw_adr", int'(ram_adr_o), 5);
    nxt(); rst = 1'b1;
    mid();
    chk("rstw_ack", int'(ack_o), 0);
    nxt(); rst = 1'b0; stb = '0; we = '0;
    nxt(); stb = 2'b10; adr = {5'd5, 5'd0};
    nxt(); mid();
    chk("rstw_rd_ack", int'(ack_o), 2);
    chk("rstw_rd_dato", int'(dat_o), 1);
    nxt(); stb = '0;

    // randomized requesters holding strobe until acknowledged
    for (int c = 0; c < 3000; c++) begin
      mid(); a_smp = ack_o;
      nxt();
      rst = ($urandom_range(0, 199) == 0);
      ena = ($urandom_range(0, 5) != 0);
      for (int k = 0; k < NR; k++) begin
        if (stb[k] && a_smp[k]) begin
          stb[k] = 1'b0;
        end else if (!stb[k] && $urandom_range(0, 1) == 1) begin
          stb[k] = 1'b1;
          we[k]  = 1'($urandom_range(0, 1));
          adr[k*AW +: AW] = AW'(8 + $urandom_range(0, 7));
          dat[k*DW +: DW] = DW'($urandom_range(0, 3));
        end
      end
    end
    nxt(); rst = 1'b0; ena = 1'b1; stb = '0;
    nxt(); mid();

    // port X untouched by the arbiter: address 3 still holds 2'b10
    chk("portx_dat", int'(datx_o), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
